// File: rtl/sync_updown_counter.sv
// Modulo-N up/down counter with saturating parallel load, terminal-count carry/borrow,
// a one-cycle wrap pulse and a sticky overflow flag.
module sync_updown_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_max, at_min;

    assign at_max = (count_q == MaxVal);
    assign at_min = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (load) begin
            // Out-of-range load values clamp so the count never leaves 0..MODULUS-1
            count_d = (din > MaxVal) ? MaxVal : din;
            ovf_d   = 1'b0;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q + One;
                end
            end else begin
                if (at_min) begin
                    count_d = MaxVal;
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = count_q - One;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;
    // High exactly when the coming edge will wrap; usable as cascade carry/borrow
    assign tc    = en & ~load & ((up & at_max) | (~up & at_min));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter: modulo-16, modulo-10 and modulo-2 instances
// sharing clock and reset, each with its own control inputs.
module tb_sync_updown_counter;

    logic clk = 1'b0;
    logic rst;

    logic       en16, up16, load16, tc16, wrap16, ovf16;
    logic [3:0] din16, c16;
    logic       en10, up10, load10, tc10, wrap10, ovf10;
    logic [3:0] din10, c10;
    logic       en2, up2, load2, tc2, wrap2, ovf2;
    logic [0:0] din2, c2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_updown_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
        .clk(clk), .rst(rst), .en(en16), .up(up16), .load(load16), .din(din16),
        .count(c16), .tc(tc16), .wrap(wrap16), .ovf(ovf16)
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
        .clk(clk), .rst(rst), .en(en10), .up(up10), .load(load10), .din(din10),
        .count(c10), .tc(tc10), .wrap(wrap10), .ovf(ovf10)
    );

    sync_updown_counter #(.WIDTH(1), .MODULUS(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .up(up2), .load(load2), .din(din2),
        .count(c2), .tc(tc2), .wrap(wrap2), .ovf(ovf2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        en16 = 0; up16 = 0; load16 = 0; din16 = '0;
        en10 = 0; up10 = 0; load10 = 0; din10 = '0;
        en2  = 0; up2  = 0; load2  = 0; din2  = '0;

        // Reset and up count
        #1;
        check_eq("rst_count", 32'(c16), 0);
        check_eq("rst_wrap", 32'(wrap16), 0);
        check_eq("rst_ovf", 32'(ovf16), 0);
        tick();
        en16 = 1; up16 = 1;
        tick();
        check_eq("rst_hold_count", 32'(c16), 0);
        rst = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check_eq("up_count", 32'(c16), 32'(i));
            check_eq("up_tc", 32'(tc16), (i == 15) ? 1 : 0);
            check_eq("up_wrap", 32'(wrap16), 0);
        end
        tick();
        check_eq("up_wrap_count", 32'(c16), 0);
        check_eq("up_wrap_pulse", 32'(wrap16), 1);
        check_eq("up_wrap_ovf", 32'(ovf16), 1);
        check_eq("up_wrap_tc", 32'(tc16), 0);
        tick();
        check_eq("up_after_count", 32'(c16), 1);
        check_eq("up_after_wrap", 32'(wrap16), 0);
        check_eq("up_after_ovf", 32'(ovf16), 1);

        // Down count and borrow
        rst = 1'b0;
        up16 = 0;
        #1;
        check_eq("dn_rst_count", 32'(c16), 0);
        check_eq("dn_rst_ovf", 32'(ovf16), 0);
        check_eq("dn_tc_at_zero", 32'(tc16), 1);
        rst = 1'b1;
        tick();
        check_eq("dn_first_count", 32'(c16), 15);
        check_eq("dn_first_wrap", 32'(wrap16), 1);
        for (int i = 14; i >= 0; i--) begin
            tick();
            check_eq("dn_count", 32'(c16), 32'(i));
            check_eq("dn_wrap", 32'(wrap16), 0);
            check_eq("dn_tc", 32'(tc16), (i == 0) ? 1 : 0);
        end
        tick();
        check_eq("dn_borrow_count", 32'(c16), 15);
        check_eq("dn_borrow_wrap", 32'(wrap16), 1);
        en16 = 0;

        // Load, clamp and priority on MODULUS = 10
        en10 = 1; up10 = 0;
        tick();
        check_eq("m10_dn_wrap_count", 32'(c10), 9);
        check_eq("m10_dn_wrap_ovf", 32'(ovf10), 1);
        load10 = 1; din10 = 4'd7;
        tick();
        check_eq("load_count", 32'(c10), 7);
        check_eq("load_ovf_clr", 32'(ovf10), 0);
        check_eq("load_wrap", 32'(wrap10), 0);
        din10 = 4'd12;
        tick();
        check_eq("clamp_count", 32'(c10), 9);
        load10 = 0; up10 = 1;
        #1;
        check_eq("m10_tc_at_9", 32'(tc10), 1);
        load10 = 1;
        #1;
        check_eq("m10_tc_load_mask", 32'(tc10), 0);
        load10 = 0;
        tick();
        check_eq("m10_wrap_count", 32'(c10), 0);
        check_eq("m10_wrap_pulse", 32'(wrap10), 1);
        check_eq("m10_wrap_ovf", 32'(ovf10), 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("m10_up_count", 32'(c10), 32'(i));
        end

        // Enable and direction change
        en10 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_count", 32'(c10), 5);
            check_eq("hold_tc", 32'(tc10), 0);
            check_eq("hold_wrap", 32'(wrap10), 0);
        end
        en10 = 1;
        for (int k = 0; k < 4; k++) begin
            up10 = (k % 2 == 0);
            tick();
            check_eq("dir_toggle", 32'(c10), (k % 2 == 0) ? 6 : 5);
        end

        // MODULUS = 2 consecutive wraps
        en2 = 1; up2 = 1;
        tick();
        check_eq("m2_count_a", 32'(c2), 1);
        check_eq("m2_wrap_a", 32'(wrap2), 0);
        check_eq("m2_tc_a", 32'(tc2), 1);
        tick();
        check_eq("m2_count_b", 32'(c2), 0);
        check_eq("m2_wrap_b", 32'(wrap2), 1);
        check_eq("m2_ovf_b", 32'(ovf2), 1);
        tick();
        check_eq("m2_count_c", 32'(c2), 1);
        check_eq("m2_wrap_c", 32'(wrap2), 0);
        tick();
        check_eq("m2_count_d", 32'(c2), 0);
        check_eq("m2_wrap_d", 32'(wrap2), 1);
        up2 = 0;
        tick();
        check_eq("m2_back_count_a", 32'(c2), 1);
        check_eq("m2_back_wrap_a", 32'(wrap2), 1);
        up2 = 1;
        tick();
        check_eq("m2_back_count_b", 32'(c2), 0);
        check_eq("m2_back_wrap_b", 32'(wrap2), 1);
        en2 = 0;

        // Mid-operation asynchronous reset
        en16 = 1; up16 = 1; load16 = 1; din16 = 4'd14;
        tick();
        check_eq("pre_load14", 32'(c16), 14);
        load16 = 0;
        tick();
        tick();
        check_eq("pre_wrap", 32'(wrap16), 1);
        for (int i = 1; i <= 9; i++) tick();
        check_eq("pre_count9", 32'(c16), 9);
        check_eq("pre_ovf", 32'(ovf16), 1);
        #2 rst = 1'b0;
        #1;
        check_eq("async_count", 32'(c16), 0);
        check_eq("async_ovf", 32'(ovf16), 0);
        check_eq("async_wrap", 32'(wrap16), 0);
        check_eq("async_ovf10", 32'(ovf10), 0);
        #34 rst = 1'b1;
        tick();
        check_eq("post_rst_hold", 32'(c16), 0);
        tick();
        check_eq("post_rst_count", 32'(c16), 1);
        check_eq("post_rst_wrap", 32'(wrap16), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
